// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 register block.
//   CR_*          : {rd, sel} addresses of the implemented CP0 registers
//   EXC_*         : ExcCode values used by the pipeline
//   STATUS_RESET  : Status value after reset (BEV set)
package cp0_pkg;

  localparam logic [7:0] CR_BADVADDR = 8'h40;
  localparam logic [7:0] CR_COUNT    = 8'h48;
  localparam logic [7:0] CR_COMPARE  = 8'h58;
  localparam logic [7:0] CR_STATUS   = 8'h60;
  localparam logic [7:0] CR_CAUSE    = 8'h68;
  localparam logic [7:0] CR_EPC      = 8'h70;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  // Address-error exceptions are the only ones that latch BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_intc_if.sv
// cp0_intc_if: mtc0/mfc0 access bus between the WB stage and CP0.
//   mtc0_we  : write strobe
//   c0_addr  : {rd, sel}, shared by read and write
//   c0_wdata : write data
//   c0_rdata : combinational read data
interface cp0_intc_if;
  logic        mtc0_we;
  logic [7:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic [31:0] c0_rdata;

  modport master (output mtc0_we, output c0_addr, output c0_wdata, input c0_rdata);
  modport slave  (input mtc0_we, input c0_addr, input c0_wdata, output c0_rdata);
endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: Count with programmable prescaler, Compare and the TI flag.
//   clk, reset   : clock, async active-high reset
//   wr_count_i   : load Count from wdata_i and restart the prescaler
//   wr_compare_i : load Compare from wdata_i and clear TI
//   count_o      : Count register
//   compare_o    : Compare register
//   ti_o         : timer interrupt flag (Cause.TI)
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_count_i,
  input  logic        wr_compare_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int unsigned DivW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(COUNT_DIV - 1);

  logic [DivW-1:0] div_cnt_q;
  logic [31:0]     count_q;
  logic [31:0]     compare_q;
  logic            ti_q;
  logic            tick;

  assign tick = (div_cnt_q == DivLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      count_q   <= '0;
    end else if (wr_count_i) begin
      div_cnt_q <= '0;
      count_q   <= wdata_i;
    end else if (tick) begin
      div_cnt_q <= '0;
      count_q   <= count_q + 32'd1;
    end else begin
      div_cnt_q <= div_cnt_q + DivW'(1);
    end
  end

  // A Compare write clears TI even if Count matches in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else if (wr_compare_i) begin
      compare_q <= wdata_i;
      ti_q      <= 1'b0;
    end else if (count_q == compare_q) begin
      ti_q      <= 1'b1;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 Status/Cause/EPC/BadVAddr, interrupt synchronisers, read mux
// and masked interrupt request; Count/Compare live in cp0_timer.
//   clk, reset        : clock, async active-high reset
//   c0                : mtc0/mfc0 bus (slave)
//   wb_ex, wb_excode,
//   wb_bd, wb_pc,
//   wb_badvaddr       : exception commit from WB
//   eret_flush        : eret commit
//   ext_int_in        : asynchronous external interrupt lines -> IP[2+i]
//   c0_epc            : EPC, eret target
//   int_req           : pending & enabled & unmasked interrupt
//   timer_int         : Cause.TI
module cp0_intc import cp0_pkg::*; #(
  parameter int unsigned N_EXT_INT   = 6,
  parameter int unsigned COUNT_DIV   = 2,
  parameter int unsigned TI_LINE     = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  cp0_intc_if.slave            c0,
  input  logic                 wb_ex,
  input  logic [4:0]           wb_excode,
  input  logic                 wb_bd,
  input  logic [31:0]          wb_pc,
  input  logic [31:0]          wb_badvaddr,
  input  logic                 eret_flush,
  input  logic [N_EXT_INT-1:0] ext_int_in,
  output logic [31:0]          c0_epc,
  output logic                 int_req,
  output logic                 timer_int
);

  logic        wr_en, wr_status, wr_cause, wr_epc, wr_count, wr_compare;
  logic [7:0]  im_q;
  logic        exl_q, ie_q, bd_q;
  logic [4:0]  exccode_q;
  logic [1:0]  ip_sw_q;
  logic [5:0]  hw_ip_q, hw_ip_d, ext_ip, ti_ip;
  logic [31:0] epc_q, badvaddr_q, count, compare;
  logic        ti;
  logic [N_EXT_INT-1:0] sync_q [SYNC_STAGES];

  // An exception in WB kills the mtc0 retiring alongside it.
  assign wr_en      = c0.mtc0_we & ~wb_ex;
  assign wr_status  = wr_en && (c0.c0_addr == CR_STATUS);
  assign wr_cause   = wr_en && (c0.c0_addr == CR_CAUSE);
  assign wr_epc     = wr_en && (c0.c0_addr == CR_EPC);
  assign wr_count   = wr_en && (c0.c0_addr == CR_COUNT);
  assign wr_compare = wr_en && (c0.c0_addr == CR_COMPARE);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .wr_count_i   (wr_count),
    .wr_compare_i (wr_compare),
    .wdata_i      (c0.c0_wdata),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ext_int_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    ext_ip = '0;
    ext_ip[N_EXT_INT-1:0] = sync_q[SYNC_STAGES-1];
    ti_ip = '0;
    ti_ip[TI_LINE-2] = ti;
    hw_ip_d = ext_ip | ti_ip;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      ip_sw_q    <= '0;
      hw_ip_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      hw_ip_q <= hw_ip_d;
      if (wr_status) begin
        im_q <= c0.c0_wdata[15:8];
        ie_q <= c0.c0_wdata[0];
      end
      if (wb_ex)           exl_q <= 1'b1;
      else if (eret_flush) exl_q <= 1'b0;
      else if (wr_status)  exl_q <= c0.c0_wdata[1];
      if (wr_cause) ip_sw_q <= c0.c0_wdata[9:8];
      if (wb_ex) begin
        exccode_q <= wb_excode;
        // Nested exceptions keep the original return point.
        if (!exl_q) begin
          bd_q  <= wb_bd;
          epc_q <= wb_bd ? wb_pc - 32'd4 : wb_pc;
        end
        if (is_addr_exc(wb_excode)) badvaddr_q <= wb_badvaddr;
      end else if (wr_epc) begin
        epc_q <= c0.c0_wdata;
      end
    end
  end

  always_comb begin
    c0.c0_rdata = '0;
    case (c0.c0_addr)
      CR_BADVADDR: c0.c0_rdata = badvaddr_q;
      CR_COUNT:    c0.c0_rdata = count;
      CR_COMPARE:  c0.c0_rdata = compare;
      CR_STATUS:   c0.c0_rdata = STATUS_RESET | {16'd0, im_q, 6'd0, exl_q, ie_q};
      CR_CAUSE:    c0.c0_rdata = {bd_q, ti, 14'd0, hw_ip_q, ip_sw_q, 1'b0, exccode_q, 2'b00};
      CR_EPC:      c0.c0_rdata = epc_q;
      default:     c0.c0_rdata = '0;
    endcase
  end

  assign int_req   = ie_q & ~exl_q & |({hw_ip_q, ip_sw_q} & im_q);
  assign c0_epc    = epc_q;
  assign timer_int = ti;

endmodule

// File: tb/tb_cp0_intc.sv
module tb_cp0_intc;

  localparam logic [7:0] A_BADV   = 8'h40;
  localparam logic [7:0] A_COUNT  = 8'h48;
  localparam logic [7:0] A_CMP    = 8'h58;
  localparam logic [7:0] A_STATUS = 8'h60;
  localparam logic [7:0] A_CAUSE  = 8'h68;
  localparam logic [7:0] A_EPC    = 8'h70;

  // Two configurations driven by identical stimulus.
  function automatic int unsigned p_div(int k);  return k == 0 ? 3 : 1; endfunction
  function automatic int unsigned p_tl(int k);   return k == 0 ? 7 : 5; endfunction
  function automatic int          p_sync(int k); return k == 0 ? 2 : 1; endfunction
  function automatic logic [5:0]  p_mask(int k); return k == 0 ? 6'h3f : 6'h07; endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_ex, wb_bd, eret_flush;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, wb_badvaddr;
  logic [5:0]  ext0;
  logic [2:0]  ext1;
  logic [31:0] epc0, epc1;
  logic        irq0, irq1, ti0, ti1;

  cp0_intc_if bus0 ();
  cp0_intc_if bus1 ();

  cp0_intc #(.N_EXT_INT(6), .COUNT_DIV(3), .TI_LINE(7), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .c0(bus0), .wb_ex(wb_ex), .wb_excode(wb_excode),
    .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush),
    .ext_int_in(ext0), .c0_epc(epc0), .int_req(irq0), .timer_int(ti0)
  );

  cp0_intc #(.N_EXT_INT(3), .COUNT_DIV(1), .TI_LINE(5), .SYNC_STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .c0(bus1), .wb_ex(wb_ex), .wb_excode(wb_excode),
    .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush),
    .ext_int_in(ext1), .c0_epc(epc1), .int_req(irq1), .timer_int(ti1)
  );

  always #5 clk = ~clk;

  // Stimulus for the current cycle.
  logic        s_we, s_wbex, s_bd, s_eret;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata, s_pc, s_bva;
  logic [4:0]  s_excode;
  logic [5:0]  s_ext;

  // Reference model: architectural state, Count kept as load value + elapsed clocks.
  logic [7:0]  m_im [2];
  logic        m_exl [2], m_ie [2], m_bd [2], m_ti [2];
  logic [4:0]  m_exc [2];
  logic [1:0]  m_ipsw [2];
  logic [5:0]  m_iphw [2];
  logic [31:0] m_epc [2], m_bad [2], m_base [2], m_cmp [2];
  int unsigned m_elapsed [2];
  logic [5:0]  m_hist [2][4];  // [j] = ext lines applied j cycles ago

  typedef struct {
    string            tag;
    logic [7:0]       addr;
    logic [1:0][31:0] rdata;
    logic [1:0][31:0] epc;
    logic [1:0]       irq;
    logic [1:0]       ti;
  } exp_t;

  exp_t exp_q[$];
  event pushed;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] m_count(int k);
    return m_base[k] + (m_elapsed[k] / p_div(k));
  endfunction

  function automatic logic [31:0] m_read(int k, logic [7:0] a);
    case (a)
      A_BADV:   return m_bad[k];
      A_COUNT:  return m_count(k);
      A_CMP:    return m_cmp[k];
      A_STATUS: return 32'h0040_0000 | (32'(m_im[k]) << 8) | (32'(m_exl[k]) << 1)
                       | 32'(m_ie[k]);
      A_CAUSE:  return (32'(m_bd[k]) << 31) | (32'(m_ti[k]) << 30) | (32'(m_iphw[k]) << 10)
                       | (32'(m_ipsw[k]) << 8) | (32'(m_exc[k]) << 2);
      A_EPC:    return m_epc[k];
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq(int k);
    logic [7:0] pend;
    pend = (8'(m_iphw[k]) << 2) | 8'(m_ipsw[k]);
    return m_ie[k] && !m_exl[k] && ((pend & m_im[k]) != 8'd0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_im[k] = '0; m_exl[k] = 0; m_ie[k] = 0; m_bd[k] = 0; m_ti[k] = 0;
      m_exc[k] = '0; m_ipsw[k] = '0; m_iphw[k] = '0; m_epc[k] = '0; m_bad[k] = '0;
      m_base[k] = '0; m_cmp[k] = '0; m_elapsed[k] = 0;
      for (int j = 0; j < 4; j++) m_hist[k][j] = '0;
    end
  endtask

  // State after the coming clock edge, from the current state and stimulus.
  task automatic m_step(int k);
    logic [31:0] cnt;
    logic        old_exl, wen;
    cnt = m_count(k);
    old_exl = m_exl[k];
    wen = s_we && !s_wbex;
    m_iphw[k] = m_hist[k][p_sync(k)] | (m_ti[k] ? 6'(1 << (p_tl(k) - 2)) : 6'd0);
    for (int j = 3; j > 1; j--) m_hist[k][j] = m_hist[k][j-1];
    m_hist[k][1] = s_ext & p_mask(k);
    if (wen && s_addr == A_CMP) begin
      m_ti[k] = 0;
      m_cmp[k] = s_wdata;
    end else if (cnt == m_cmp[k]) begin
      m_ti[k] = 1;
    end
    if (wen && s_addr == A_COUNT) begin
      m_base[k] = s_wdata;
      m_elapsed[k] = 0;
    end else begin
      m_elapsed[k]++;
    end
    if (wen && s_addr == A_STATUS) begin
      m_im[k] = s_wdata[15:8];
      m_ie[k] = s_wdata[0];
    end
    if (s_wbex) m_exl[k] = 1;
    else if (s_eret) m_exl[k] = 0;
    else if (wen && s_addr == A_STATUS) m_exl[k] = s_wdata[1];
    if (wen && s_addr == A_CAUSE) m_ipsw[k] = s_wdata[9:8];
    if (wen && s_addr == A_EPC) m_epc[k] = s_wdata;
    if (s_wbex) begin
      m_exc[k] = s_excode;
      if (!old_exl) begin
        m_bd[k] = s_bd;
        m_epc[k] = s_bd ? s_pc - 32'd4 : s_pc;
      end
      if (s_excode == 5'h04 || s_excode == 5'h05) m_bad[k] = s_bva;
    end
  endtask

  task automatic apply();
    bus0.mtc0_we = s_we; bus0.c0_addr = s_addr; bus0.c0_wdata = s_wdata;
    bus1.mtc0_we = s_we; bus1.c0_addr = s_addr; bus1.c0_wdata = s_wdata;
    wb_ex = s_wbex; wb_excode = s_excode; wb_bd = s_bd; wb_pc = s_pc;
    wb_badvaddr = s_bva; eret_flush = s_eret;
    ext0 = s_ext; ext1 = s_ext[2:0];
  endtask

  task automatic push_exp(string tag);
    exp_t e;
    e.tag = tag;
    e.addr = s_addr;
    for (int k = 0; k < 2; k++) begin
      e.rdata[k] = m_read(k, s_addr);
      e.epc[k] = m_epc[k];
      e.irq[k] = m_irq(k);
      e.ti[k] = m_ti[k];
    end
    exp_q.push_back(e);
    -> pushed;
  endtask

  task automatic idle();
    s_we = 0; s_wbex = 0; s_eret = 0;
  endtask

  task automatic step(string tag);
    @(negedge clk);
    apply();
    push_exp(tag);
    for (int k = 0; k < 2; k++) m_step(k);
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d, string tag);
    s_we = 1; s_addr = a; s_wdata = d;
    step(tag);
    s_we = 0;
  endtask

  task automatic rd(logic [7:0] a, int n, string tag);
    s_addr = a;
    repeat (n) step(tag);
  endtask

  task automatic exc(logic [4:0] code, logic bd, logic [31:0] pc, logic [31:0] bva,
                     string tag);
    s_wbex = 1; s_excode = code; s_bd = bd; s_pc = pc; s_bva = bva;
    step(tag);
    s_wbex = 0;
  endtask

  // Reset asserted between clock edges; state must clear without a clock.
  task automatic do_reset();
    logic [7:0] addrs [6];
    addrs = '{A_STATUS, A_CAUSE, A_EPC, A_COUNT, A_BADV, A_CMP};
    @(negedge clk);
    #3;
    reset = 1;
    idle();
    s_ext = '0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      s_addr = addrs[i];
      apply();
      push_exp("reset");
      #2;
    end
    @(posedge clk);
    #2;
    reset = 0;
  endtask

  task automatic chk(string tag, string what, int k, logic [7:0] a,
                     logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s inst%0d addr=%02h got=%08h exp=%08h", tag, what, k, a, got, want);
    end
  endtask

  // Monitor: samples the DUTs shortly after each expectation is issued.
  initial begin
    exp_t e;
    forever begin
      @(pushed);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard empty got=0 exp=1");
      end else begin
        e = exp_q.pop_front();
        chk(e.tag, "rdata", 0, e.addr, bus0.c0_rdata, e.rdata[0]);
        chk(e.tag, "rdata", 1, e.addr, bus1.c0_rdata, e.rdata[1]);
        chk(e.tag, "epc", 0, e.addr, epc0, e.epc[0]);
        chk(e.tag, "epc", 1, e.addr, epc1, e.epc[1]);
        chk(e.tag, "int_req", 0, e.addr, 32'(irq0), 32'(e.irq[0]));
        chk(e.tag, "int_req", 1, e.addr, 32'(irq1), 32'(e.irq[1]));
        chk(e.tag, "timer_int", 0, e.addr, 32'(ti0), 32'(e.ti[0]));
        chk(e.tag, "timer_int", 1, e.addr, 32'(ti1), 32'(e.ti[1]));
      end
    end
  end

  initial begin
    logic [7:0] pick [8];
    logic [4:0] codes [7];
    codes = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c};
    idle();
    s_addr = A_STATUS; s_wdata = '0; s_excode = '0; s_bd = 0; s_pc = '0; s_bva = '0;
    s_ext = '0;
    apply();
    do_reset();

    // Prescaler and wrap.
    wr(A_COUNT, 32'hffff_fffe, "count_load");
    rd(A_COUNT, 7, "prescale_wrap");

    // Timer interrupt and Compare-write clear.
    wr(A_STATUS, 32'h0000_8001, "status_wr");
    wr(A_CMP, 32'h0000_0010, "cmp_wr");
    wr(A_COUNT, 32'h0000_000e, "count_wr");
    rd(A_CAUSE, 10, "timer_ti");
    wr(A_CMP, 32'h0000_1000, "cmp_clear");
    rd(A_CAUSE, 3, "ti_cleared");

    // Nested exception.
    exc(5'h04, 1'b1, 32'hbfc0_0104, 32'h0000_0001, "exc_adel");
    rd(A_EPC, 1, "exc_epc");
    rd(A_CAUSE, 1, "exc_cause");
    rd(A_BADV, 1, "exc_badv");
    exc(5'h08, 1'b0, 32'h0000_0400, 32'hdead_beef, "exc_nested");
    rd(A_EPC, 1, "nested_epc");
    rd(A_CAUSE, 1, "nested_cause");
    rd(A_BADV, 1, "nested_badv");

    // External interrupt, then eret clearing EXL.
    wr(A_STATUS, 32'h0000_0401, "status_ext");
    s_ext = 6'h01;
    rd(A_CAUSE, 5, "ext_int");
    s_ext = 6'h00;
    rd(A_CAUSE, 4, "ext_release");
    wr(A_STATUS, 32'h0000_0403, "status_exl");
    s_eret = 1;
    rd(A_STATUS, 1, "eret");
    s_eret = 0;
    rd(A_STATUS, 2, "eret_exl");

    // mtc0 EPC loses to a same-cycle exception; unmapped and read-only addresses.
    s_we = 1; s_addr = A_EPC; s_wdata = 32'h0000_1234;
    exc(5'h08, 1'b0, 32'h8000_0200, 32'h0, "epc_vs_exc");
    s_we = 0;
    rd(A_EPC, 2, "epc_after");
    rd(8'h08, 1, "unmapped");
    wr(A_BADV, 32'h0000_ffff, "badv_ro");
    rd(A_BADV, 1, "badv_after");

    do_reset();

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      pick = '{A_BADV, A_COUNT, A_CMP, A_STATUS, A_CAUSE, A_EPC, 8'h08, 8'($urandom)};
      idle();
      s_addr = pick[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) begin
        s_we = 1;
        s_wdata = $urandom;
        if (s_addr == A_COUNT && $urandom_range(0, 1) == 1)
          s_wdata = m_cmp[0] - 32'($urandom_range(0, 4));
        if (s_addr == A_STATUS && $urandom_range(0, 1) == 1)
          s_wdata = s_wdata & ~32'h2 | 32'h1;
      end
      if ($urandom_range(0, 15) == 0) begin
        s_wbex = 1;
        s_excode = codes[$urandom_range(0, 6)];
        s_bd = 1'($urandom);
        s_pc = $urandom & ~32'h3;
        s_bva = $urandom;
      end
      if ($urandom_range(0, 11) == 0) s_eret = 1;
      if ($urandom_range(0, 7) == 0) s_ext = 6'($urandom);
      step("random");
      if (c == 750) do_reset();
    end
    idle();
    rd(A_CAUSE, 2, "final");
    #20;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
